// File: rtl/issue_pkg.sv
// Shared state encoding and default sizing for the issue-stage FIFO controller.
package issue_pkg;

    localparam int ISSUE_FIFO_DEPTH = 16;
    localparam int ISSUE_PR_W       = 9;
    localparam int ISSUE_FLUSH_HOLD = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/issue_fifo_prdec.sv
// Count-to-near-full one-hot decoder, reusable by any queue with a credit-style throttle.
// Latency: combinational.
// Backpressure: none; the consumer throttles its writes from the returned vector.
module issue_fifo_prdec #(
    parameter int DEPTH = 16,
    parameter int CW    = 5,
    parameter int PR_W  = 9
) (
    input  logic [CW-1:0]   count_i,
    output logic [PR_W-1:0] fifo_pr_o
);

    logic [CW-1:0] free_cnt;

    // Bit 0 covers every "plenty of room" level, so the vector stays one-hot.
    always_comb begin
        free_cnt     = CW'(DEPTH) - count_i;
        fifo_pr_o    = '0;
        fifo_pr_o[0] = (free_cnt >= CW'(PR_W - 1));
        for (int k = 1; k < PR_W; k++) begin
            fifo_pr_o[k] = (free_cnt == CW'(PR_W - 1 - k));
        end
    end

endmodule

// File: rtl/issue_fifo_ctrl.sv
// Issue FIFO pointer/occupancy controller with flush sequencing and near-full vector.
// Latency: accepted write visible next cycle; flush to resumed RUN takes 1 + FLUSH_HOLD cycles.
// Backpressure: writes refused when full or not in RUN; allocation throttles from fifo_pr.
module issue_fifo_ctrl
    import issue_pkg::*;
#(
    parameter int DEPTH      = ISSUE_FIFO_DEPTH,
    parameter int AW         = 4,
    parameter int PR_W       = ISSUE_PR_W,
    parameter int FLUSH_HOLD = ISSUE_FLUSH_HOLD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wen,
    input  logic            ren,
    input  logic            flush,
    output logic [AW-1:0]   waddr,
    output logic [AW-1:0]   raddr,
    output logic            ram_we,
    output logic            o_valid,
    output logic [AW:0]     count,
    output logic [PR_W-1:0] fifo_pr,
    output logic            o_busy,
    output logic            err_ovf,
    output logic            err_udf
);

    localparam int HW = $clog2(FLUSH_HOLD + 1);

    issue_state_e  state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_udf_q, err_udf_d;
    logic          run, full, empty, wacc, racc;

    assign run   = (state_q == RUN);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    // A flush in RUN wins over same-cycle traffic.
    assign wacc  = run & ~flush & wen & ~full;
    assign racc  = run & ~flush & ren & ~empty;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        hold_d    = hold_q;
        err_ovf_d = err_ovf_q | (run & wen & full);
        err_udf_d = err_udf_q | (run & ren & empty);
        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                    wptr_d  = '0;
                    rptr_d  = '0;
                    count_d = '0;
                end else begin
                    wptr_d  = wptr_q + (AW+1)'(wacc);
                    rptr_d  = rptr_q + (AW+1)'(racc);
                    count_d = count_q + (AW+1)'(wacc) - (AW+1)'(racc);
                end
            end
            FLUSH: begin
                state_d = HOLD;
                hold_d  = HW'(FLUSH_HOLD);
            end
            HOLD: begin
                // A fresh flush restarts the hold window to stay aligned with allocation.
                if (flush) begin
                    hold_d = HW'(FLUSH_HOLD);
                end else if (hold_q <= HW'(1)) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            hold_q    <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    issue_fifo_prdec #(
        .DEPTH (DEPTH),
        .CW    (AW + 1),
        .PR_W  (PR_W)
    ) u_prdec (
        .count_i   (count_q),
        .fifo_pr_o (fifo_pr)
    );

    assign waddr   = wptr_q[AW-1:0];
    assign raddr   = rptr_q[AW-1:0];
    assign ram_we  = wacc;
    assign o_valid = run & ~empty;
    assign count   = count_q;
    assign o_busy  = ~run;
    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;

endmodule

// File: tb/tb_issue_fifo_ctrl.sv
// Self-checking bench for issue_fifo_ctrl: vector table, corner sequences, random traffic vs model.
module tb_issue_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PR_W  = 9;
    localparam int FH    = 4;

    logic            clk = 1'b0;
    logic            reset, wen, ren, flush;
    logic [AW-1:0]   waddr, raddr;
    logic            ram_we, o_valid, o_busy, err_ovf, err_udf;
    logic [AW:0]     count;
    logic [PR_W-1:0] fifo_pr;

    issue_fifo_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .PR_W(PR_W), .FLUSH_HOLD(FH)
    ) dut (
        .clk(clk), .reset(reset), .wen(wen), .ren(ren), .flush(flush),
        .waddr(waddr), .raddr(raddr), .ram_we(ram_we), .o_valid(o_valid),
        .count(count), .fifo_pr(fifo_pr), .o_busy(o_busy),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: occupancy, head/tail slots, and how many upcoming cycles are blocked.
    int m_occ = 0, m_wr = 0, m_rd = 0, m_busy = 0;
    bit m_ovf = 1'b0, m_udf = 1'b0;

    // Output snapshot taken mid-cycle, before the edge that consumes the inputs.
    logic            s_we, s_valid, s_busy, s_udf, s_ovf;
    logic [AW-1:0]   s_waddr, s_raddr;
    logic [AW:0]     s_count;
    logic [PR_W-1:0] s_pr;

    typedef struct {
        bit         w, r, f;
        int         cnt;
        bit         we, vld, busy, udf;
        logic [8:0] pr;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PR_W-1:0] pr_ref(input int occ);
        int free;
        logic [PR_W-1:0] v;
        free = DEPTH - occ;
        v    = '0;
        if (free >= PR_W - 1) v[0] = 1'b1;
        else                  v[PR_W - 1 - free] = 1'b1;
        return v;
    endfunction

    task automatic model_check();
        bit run;
        run = (m_busy == 0);
        chk("waddr",   32'(waddr),   32'(m_wr));
        chk("raddr",   32'(raddr),   32'(m_rd));
        chk("ram_we",  32'(ram_we),  32'(run && !flush && wen && (m_occ < DEPTH)));
        chk("o_valid", 32'(o_valid), 32'(run && (m_occ > 0)));
        chk("count",   32'(count),   32'(m_occ));
        chk("fifo_pr", 32'(fifo_pr), 32'(pr_ref(m_occ)));
        chk("o_busy",  32'(o_busy),  32'(!run));
        chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
        chk("err_udf", 32'(err_udf), 32'(m_udf));
    endtask

    task automatic model_update(input bit w, input bit r, input bit f, input bit rst);
        int wa, ra;
        if (rst) begin
            m_occ = 0; m_wr = 0; m_rd = 0; m_busy = 0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (m_busy == 0) begin
            if (w && m_occ == DEPTH) m_ovf = 1'b1;
            if (r && m_occ == 0)     m_udf = 1'b1;
            if (f) begin
                m_occ = 0; m_wr = 0; m_rd = 0; m_busy = 1 + FH;
            end else begin
                wa = (w && m_occ < DEPTH) ? 1 : 0;
                ra = (r && m_occ > 0) ? 1 : 0;
                m_occ = m_occ + wa - ra;
                m_wr  = (m_wr + wa) % DEPTH;
                m_rd  = (m_rd + ra) % DEPTH;
            end
        end else if (f) begin
            m_busy = FH;
        end else begin
            m_busy = m_busy - 1;
        end
    endtask

    task automatic step(input bit w, input bit r, input bit f, input bit rst);
        wen = w; ren = r; flush = f; reset = rst;
        @(negedge clk);
        model_check();
        s_we = ram_we; s_valid = o_valid; s_busy = o_busy; s_udf = err_udf; s_ovf = err_ovf;
        s_waddr = waddr; s_raddr = raddr; s_count = count; s_pr = fifo_pr;
        @(posedge clk);
        model_update(w, r, f, rst);
        #1;
    endtask

    initial begin
        int nb;
        //        w  r  f  cnt we vld busy udf pr
        tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0, 9'h001};
        tbl[1]  = '{1, 0, 0, 1, 1, 1, 0, 0, 9'h001};
        tbl[2]  = '{0, 1, 0, 2, 0, 1, 0, 0, 9'h001};
        tbl[3]  = '{0, 1, 0, 1, 0, 1, 0, 0, 9'h001};
        tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 0, 9'h001};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 9'h001};
        tbl[6]  = '{1, 0, 1, 0, 0, 0, 0, 1, 9'h001};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 1, 1, 9'h001};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 1, 1, 9'h001};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 1, 1, 9'h001};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 1, 1, 9'h001};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 1, 1, 9'h001};
        tbl[12] = '{1, 0, 0, 0, 1, 0, 0, 1, 9'h001};
        tbl[13] = '{0, 0, 0, 1, 0, 1, 0, 1, 9'h001};

        reset = 1'b1; wen = 1'b0; ren = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_waddr",   32'(waddr),   32'd0);
        chk("rst_raddr",   32'(raddr),   32'd0);
        chk("rst_valid",   32'(o_valid), 32'd0);
        chk("rst_busy",    32'(o_busy),  32'd0);
        chk("rst_ram_we",  32'(ram_we),  32'd0);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_fifo_pr", 32'(fifo_pr), 32'h001);
        chk("rst_errs",    32'({err_ovf, err_udf}), 32'd0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].f, 1'b0);
            chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_we", i),    32'(s_we),    32'(tbl[i].we));
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_busy", i),  32'(s_busy),  32'(tbl[i].busy));
            chk($sformatf("tbl%0d_udf", i),   32'(s_udf),   32'(tbl[i].udf));
            chk($sformatf("tbl%0d_pr", i),    32'(s_pr),    32'(tbl[i].pr));
        end

        // Fill to full, then overflow attempt.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk("fill_waddr", 32'(s_waddr), 32'(i));
            chk("fill_we",    32'(s_we),    32'd1);
            chk("fill_count", 32'(s_count), 32'(i));
            chk("fill_pr",    32'(s_pr),    (i <= 8) ? 32'h001 : (32'h001 << (i - 8)));
        end
        chk("full_count", 32'(count),   32'd16);
        chk("full_pr",    32'(fifo_pr), 32'h100);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_we", 32'(s_we), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_count", 32'(s_count), 32'd16);
        chk("ovf_flag",  32'(s_ovf),   32'd1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(err_ovf), 32'd1);

        // Drain to 5, then steady-state simultaneous read/write across the wrap.
        repeat (11) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            chk("rw_count", 32'(s_count), 32'd5);
            chk("rw_valid", 32'(s_valid), 32'd1);
            chk("rw_waddr", 32'(s_waddr), 32'(k % 16));
            chk("rw_raddr", 32'(s_raddr), 32'((11 + k) % 16));
        end

        // Flush from count 10 with a colliding write.
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd10);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_we",    32'(s_we),   32'd0);
        chk("flush_count", 32'(count),  32'd0);
        chk("flush_busy",  32'(o_busy), 32'd1);
        nb = 0;
        while (o_busy === 1'b1 && nb < 20) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk("hold_we", 32'(s_we), 32'd0);
            nb++;
        end
        chk("flush_busy_cycles", 32'(nb), 32'd5);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume_we", 32'(s_we), 32'd1);

        // Second flush on the second HOLD cycle restarts the hold window.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        nb = 0;
        while (o_busy === 1'b1 && nb < 20) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("reflush_count", 32'(s_count), 32'd0);
            nb++;
        end
        chk("reflush_extra_cycles", 32'(nb), 32'd4);
        chk("reflush_errs", 32'({err_ovf, err_udf}), 32'd0);

        // Reset during HOLD clears everything, including a sticky error.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("udf_set", 32'(err_udf), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hold_rst_busy",  32'(o_busy),  32'd0);
        chk("hold_rst_count", 32'(count),   32'd0);
        chk("hold_rst_errs",  32'({err_ovf, err_udf}), 32'd0);
        chk("hold_rst_pr",    32'(fifo_pr), 32'h001);

        // Random traffic with alternating fill/drain bias.
        for (int c = 0; c < 3000; c++) begin
            bit w, r, f, rs;
            bit fillb;
            fillb = ((c / 150) % 2) == 0;
            w  = $urandom_range(99) < (fillb ? 75 : 30);
            r  = $urandom_range(99) < (fillb ? 30 : 75);
            f  = $urandom_range(199) == 0;
            rs = $urandom_range(999) == 0;
            step(w, r, f, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
